// File: rtl/serial_arbiter_pkg.sv
// rtl/serial_arbiter_pkg.sv - shared types and constants for the serial arbiter
package serial_arbiter_pkg;

  localparam int BITS_PER_FRAME = 8;
  localparam int NUM_REQ        = 2;
  localparam int CNT_W          = $clog2(BITS_PER_FRAME);
  localparam int IDX_W          = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_FRAME - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/serial_arbiter_rr_pick.sv
// rtl/serial_arbiter_rr_pick.sv - round-robin winner select, one-hot result
module rr_pick
  import serial_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [IDX_W-1:0] other;

  always_comb begin
    // With two requesters the non-preferred one is simply the inverted pointer.
    other = ~rr_ptr;
    grant = '0;
    if (req[rr_ptr]) begin
      grant[rr_ptr] = 1'b1;
    end else if (req[other]) begin
      grant[other] = 1'b1;
    end
  end

endmodule

// File: rtl/serial_arbiter.sv
// rtl/serial_arbiter.sv - arbitrates two serial requesters onto one deserializer
module serial_arbiter
  import serial_arbiter_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [NUM_REQ-1:0] data_in,
  input  logic [NUM_REQ-1:0] write_in,
  output logic [NUM_REQ-1:0] grant_out,
  output logic               des_data_out,
  output logic               des_write_out,
  input  logic               des_status_in,
  input  logic               des_ready_in,
  output logic               des_ack_out,
  input  logic               cons_ack_in,
  output logic [IDX_W-1:0]   owner_out,
  output logic               frame_done_out
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic               shifting;
  logic               fwd;

  rr_pick u_rr_pick (
    .req    (req_in),
    .rr_ptr (rr_ptr_q),
    .grant  (pick)
  );

  // Only the owner's lanes reach the deserializer; the other requester is never looked at.
  assign shifting      = (state_q == SHIFT);
  assign fwd           = shifting && write_in[owner_q] && !des_status_in;
  assign des_write_out = fwd;
  assign des_data_out  = shifting && data_in[owner_q];

  assign grant_out      = grant_q;
  assign owner_out      = owner_q;
  assign des_ack_out    = ack_q;
  assign frame_done_out = ack_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_in) begin
          grant_d = pick;
          owner_d = onehot_to_idx(pick);
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (fwd) begin
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = WAIT_ACK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        if (des_ready_in && cons_ack_in) begin
          ack_d    = 1'b1;
          grant_d  = '0;
          rr_ptr_d = owner_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
    end
  end

endmodule

// File: tb/tb_serial_arbiter.sv
// tb/tb_serial_arbiter.sv - directed and randomized bench for serial_arbiter
`timescale 1ns/1ps
module tb_serial_arbiter;

  localparam time HALF = 5000ns;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_in = '0, data_in = '0, write_in = '0;
  logic       des_status_in = 1'b0, des_ready_in = 1'b0, cons_ack_in = 1'b0;
  logic [1:0] grant_out;
  logic       des_data_out, des_write_out, des_ack_out, frame_done_out;
  logic       owner_out;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a frame is "busy" from grant to ack; sent counts forwarded bits, 8 means waiting for ack.
  bit   m_busy = 1'b0, m_owner = 1'b0, m_ptr = 1'b0, m_ack = 1'b0, m_ack_n;
  int   m_sent = 0;
  logic [1:0] e_grant;
  logic e_write, e_data;
  bit   shifting;

  int         cap_cnt = 0;
  int         ack_cnt = 0;
  logic [7:0] cap_byte = '0;

  serial_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .req_in         (req_in),
    .data_in        (data_in),
    .write_in       (write_in),
    .grant_out      (grant_out),
    .des_data_out   (des_data_out),
    .des_write_out  (des_write_out),
    .des_status_in  (des_status_in),
    .des_ready_in   (des_ready_in),
    .des_ack_out    (des_ack_out),
    .cons_ack_in    (cons_ack_in),
    .owner_out      (owner_out),
    .frame_done_out (frame_done_out)
  );

  always #(HALF) clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      m_busy = 1'b0; m_owner = 1'b0; m_ptr = 1'b0; m_ack = 1'b0; m_sent = 0;
      chk("rst_grant", 32'(grant_out), 32'(2'b00));
      chk("rst_write", 32'(des_write_out), 32'(1'b0));
      chk("rst_data", 32'(des_data_out), 32'(1'b0));
      chk("rst_ack", 32'(des_ack_out), 32'(1'b0));
      chk("rst_done", 32'(frame_done_out), 32'(1'b0));
      chk("rst_owner", 32'(owner_out), 32'(1'b0));
    end else begin
      e_grant  = !m_busy ? 2'b00 : (m_owner ? 2'b10 : 2'b01);
      shifting = m_busy && (m_sent < 8);
      e_write  = shifting && write_in[m_owner] && !des_status_in;
      e_data   = shifting && data_in[m_owner];
      chk("grant", 32'(grant_out), 32'(e_grant));
      chk("des_write", 32'(des_write_out), 32'(e_write));
      chk("des_data", 32'(des_data_out), 32'(e_data));
      chk("des_ack", 32'(des_ack_out), 32'(m_ack));
      chk("frame_done", 32'(frame_done_out), 32'(m_ack));
      if (m_busy) chk("owner", 32'(owner_out), 32'(m_owner));
      m_ack_n = 1'b0;
      if (!m_busy) begin
        if (req_in != 2'b00) begin
          m_owner = req_in[m_ptr] ? m_ptr : ~m_ptr;
          m_busy  = 1'b1;
          m_sent  = 0;
        end
      end else if (m_sent < 8) begin
        if (e_write) m_sent++;
      end else if (des_ready_in && cons_ack_in) begin
        m_busy  = 1'b0;
        m_ptr   = ~m_owner;
        m_ack_n = 1'b1;
      end
      m_ack = m_ack_n;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (des_write_out) begin
        cap_byte = {cap_byte[6:0], des_data_out};
        cap_cnt++;
      end
      if (des_ack_out) ack_cnt++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_grant(input string name, input logic [1:0] exp);
    int n = 0;
    while (grant_out == 2'b00 && n < 6) begin
      tick();
      n++;
    end
    chk(name, 32'(grant_out), 32'(exp));
  endtask

  // Drive nbits of pattern (MSB first) from requester own; non-owner lanes toggle randomly.
  task automatic send_bits(input bit own, input logic [7:0] pattern, input int nbits, input int stall_at);
    for (int i = 0; i < nbits; i++) begin
      if (i == stall_at) begin
        des_status_in = 1'b1;
        for (int s = 0; s < 3; s++) begin
          write_in[own]  = 1'b1;
          data_in[own]   = 1'($urandom);
          write_in[~own] = 1'($urandom);
          data_in[~own]  = 1'($urandom);
          tick();
        end
        chk("stall_hold", 32'(cap_cnt), 32'(stall_at));
        des_status_in = 1'b0;
      end
      data_in[own]   = pattern[7-i];
      write_in[own]  = 1'b1;
      write_in[~own] = 1'($urandom);
      data_in[~own]  = 1'($urandom);
      tick();
    end
    write_in = '0;
    data_in  = '0;
  endtask

  task automatic frame(input bit own, input logic [7:0] pattern, input int stall_at);
    cap_cnt  = 0;
    cap_byte = '0;
    send_bits(own, pattern, 8, stall_at);
    chk("bit_count", 32'(cap_cnt), 32'd8);
    chk("byte_value", 32'(cap_byte), 32'(pattern));
    chk("wait_no_write", 32'(des_write_out), 32'(1'b0));
    chk("wait_grant_hold", 32'(grant_out), own ? 32'(2'b10) : 32'(2'b01));
  endtask

  task automatic ack_frame(input bit own);
    cons_ack_in  = 1'b1;
    des_ready_in = 1'b0;
    tick();
    tick();
    chk("ack_no_ready", 32'(des_ack_out), 32'(1'b0));
    chk("owner_in_wait", 32'(owner_out), 32'(own));
    ack_cnt      = 0;
    des_ready_in = 1'b1;
    tick();
    chk("ack_pulse", 32'(des_ack_out), 32'(1'b1));
    chk("done_pulse", 32'(frame_done_out), 32'(1'b1));
    chk("grant_cleared", 32'(grant_out), 32'(2'b00));
    des_ready_in = 1'b0;
    cons_ack_in  = 1'b0;
    tick();
    chk("ack_one_cycle", 32'(des_ack_out), 32'(1'b0));
    chk("ack_count", 32'(ack_cnt), 32'd1);
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single requester, fixed byte.
    req_in = 2'b01;
    chk("grant_before_edge", 32'(grant_out), 32'(2'b00));
    tick();
    chk("grant_one_cycle", 32'(grant_out), 32'(2'b01));
    frame(1'b0, 8'b1011_0010, -1);
    req_in = 2'b00;
    ack_frame(1'b0);

    // Non-owner write strobes and a 3-cycle stall after bit 4.
    req_in = 2'b01;
    wait_grant("grant_r0_again", 2'b01);
    cap_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      write_in[1] = ~write_in[1];
      data_in[1]  = 1'($urandom);
      tick();
    end
    chk("other_write_ignored", 32'(cap_cnt), 32'd0);
    write_in = '0;
    frame(1'b0, 8'b1100_1010, 4);
    req_in = 2'b00;
    ack_frame(1'b0);

    // Round-robin alternation under constant contention after reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_in = 2'b11;
    wait_grant("rr_first", 2'b01);
    frame(1'b0, 8'h5a, -1);
    ack_frame(1'b0);
    wait_grant("rr_second", 2'b10);
    frame(1'b1, 8'hc3, -1);
    ack_frame(1'b1);
    wait_grant("rr_third", 2'b01);
    frame(1'b0, 8'h81, 2);
    req_in = 2'b00;
    ack_frame(1'b0);

    // Reset mid-frame after bit 5, with rr pointer left at requester 1.
    req_in = 2'b01;
    wait_grant("pre_reset_grant", 2'b01);
    cap_cnt = 0;
    send_bits(1'b0, 8'hff, 5, -1);
    ack_cnt = 0;
    reset   = 1'b1;
    #1;
    chk("async_grant", 32'(grant_out), 32'(2'b00));
    chk("async_write", 32'(des_write_out), 32'(1'b0));
    chk("async_ack", 32'(des_ack_out), 32'(1'b0));
    chk("async_owner", 32'(owner_out), 32'(1'b0));
    req_in = 2'b11;
    tick();
    reset = 1'b0;
    wait_grant("post_reset_tie", 2'b01);
    chk("no_ack_on_reset", 32'(ack_cnt), 32'd0);
    frame(1'b0, 8'h3c, -1);
    req_in = 2'b00;
    ack_frame(1'b0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      req_in        = 2'($urandom);
      data_in       = 2'($urandom);
      write_in      = ($urandom_range(0, 9) < 7) ? 2'b11 : 2'($urandom);
      des_status_in = ($urandom_range(0, 9) < 2);
      des_ready_in  = 1'($urandom);
      cons_ack_in   = 1'($urandom);
      reset         = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    req_in = '0; write_in = '0; data_in = '0;
    des_status_in = 1'b0; des_ready_in = 1'b0; cons_ack_in = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #(HALF * 2 * 20000);
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule

// File: doc/serial_arbiter.md
SERIAL_ARBITER -- requirements
Module: serial_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 clock  in  1  system clock; the block SHALL run at 100 kHz.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_in  in  2  per-requester request; bit i high means requester i has a byte to send.
REQ-005 data_in  in  2  per-requester serial data bit.
REQ-006 write_in  in  2  per-requester bit-valid strobe.
REQ-007 grant_out  out  2  one-hot grant; 00 when no requester owns the deserializer.
REQ-008 des_data_out  out  1  serial bit forwarded to the deserializer.
REQ-009 des_write_out  out  1  write strobe to the deserializer.
REQ-010 des_status_in  in  1  deserializer busy; high means it accepts no bits.
REQ-011 des_ready_in  in  1  deserializer data_ready.
REQ-012 des_ack_out  out  1  ack pulse to the deserializer.
REQ-013 cons_ack_in  in  1  downstream consumer has taken the byte.
REQ-014 owner_out  out  1  index of the requester whose byte is in the deserializer; valid in WAIT_ACK.
REQ-015 frame_done_out  out  1  one-cycle pulse when a frame is acknowledged.

Function
REQ-016 FSM states SHALL be IDLE, SHIFT and WAIT_ACK, all registered.
REQ-017 IDLE: if any req_in bit is high, the block SHALL select a winner by round-robin, register grant_out one-hot, load owner and go to SHIFT on the next edge.
- Round-robin: the requester whose index equals rr_ptr wins a tie; otherwise the only requester wins.
REQ-018 SHIFT: des_data_out SHALL equal data_in[owner] combinationally, and des_write_out SHALL equal write_in[owner] AND NOT des_status_in.
REQ-019 The 3-bit bit counter SHALL increment on each cycle where des_write_out is high.
REQ-020 When des_write_out is high and the counter is 7, the block SHALL clear the counter and enter WAIT_ACK on the next edge.
- Total: exactly 8 forwarded bits per frame.
REQ-021 write_in from the non-granted requester SHALL be ignored in every state.
REQ-022 While des_status_in is high in SHIFT, no bit SHALL be forwarded, the counter SHALL hold and the grant SHALL hold.
REQ-023 Deassertion of req_in[owner] mid-frame SHALL be ignored; the grant SHALL hold until the frame completes.
REQ-024 WAIT_ACK: des_write_out SHALL be 0 and grant_out SHALL hold.
REQ-025 WAIT_ACK: when des_ready_in and cons_ack_in are both high in the same cycle, the block SHALL on the next edge:
- pulse des_ack_out and frame_done_out high for exactly one cycle;
- clear grant_out;
- set rr_ptr to the requester other than the owner;
- return to IDLE.
REQ-026 In WAIT_ACK, cons_ack_in without des_ready_in SHALL be ignored.
REQ-027 A new grant SHALL NOT be issued in the cycle des_ack_out is high.
- Minimum gap between grants: 1 cycle in IDLE.
REQ-028 des_data_out and des_write_out SHALL be 0 outside SHIFT.

Reset
REQ-029 Reset SHALL asynchronously force the following values:
- state IDLE;
- grant_out 00;
- counter 0;
- rr_ptr 0;
- owner_out 0;
- des_ack_out 0;
- frame_done_out 0;
- des_write_out 0;
- des_data_out 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no ack pulse; the first grant after release SHALL go to requester 0 on a tie.

Structure
REQ-031 A shared package SHALL hold:
- the state enum (IDLE, SHIFT, WAIT_ACK);
- constant BITS_PER_FRAME = 8;
- constant NUM_REQ = 2.
REQ-032 Round-robin selection SHALL be one sub-module, rr_pick: combinational, inputs req and rr_ptr, output one-hot grant.
REQ-033 The RTL SHALL instantiate no deserializer; it connects to one at the top level.

Verification
REQ-034 Verification SHALL cover the following directed scenarios:
- req_in=01, 8 bits 1,0,1,1,0,0,1,0 with write_in[0] high, status 0 -> grant_out=01 one cycle after request, 8 des_write_out pulses with matching bits, then WAIT_ACK.
- req_in=11 after reset -> requester 0 granted; after ack, req_in still 11 -> requester 1 granted next; after that ack -> requester 0 granted.
- des_status_in high for 3 cycles mid-frame, after bit 4 -> no forwarding during those cycles, counter holds at 4, frame still totals 8 bits.
- write_in[1] toggling while requester 0 is granted -> zero effect on des_write_out and the counter.
- WAIT_ACK with cons_ack_in=1, des_ready_in=0 -> no ack; both high -> des_ack_out and frame_done_out each exactly one cycle, owner_out=granted index.
- reset pulse after bit 5 -> all outputs at reset values immediately, no des_ack_out, clean frame on next request.
